// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single DataMemory port between the MEM stage
// (priority owner) and a word-access DMA/loader master. The DMA is forced in
// after STARVE_MAX consecutive lost cycles. A DMA access spans grant, issue
// and response cycles, and its ack is a one-cycle pulse.
// Optional build macro DMEM_ARB_STATS_EN adds saturating stall/grant counters.
module dmem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [1:0]    cpu_nbytes,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_wr,
    input  logic [1:0]    dma_nbytes,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          mem_rd_en,
    output logic          mem_wr_en,
    output logic [1:0]    mem_nbytes,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_stall_cycles,
    output logic [15:0]   stat_dma_grants
`endif
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {ST_IDLE, ST_DMA_ISSUE, ST_DMA_RESP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_starve_cnt;
    logic          r_dma_ack;
    logic [DW-1:0] r_dma_rdata;
    logic          r_req_wr;
    logic [1:0]    r_req_nbytes;
    logic [AW-1:0] r_req_addr;
    logic [DW-1:0] r_req_wdata;
    logic          w_starved;
    logic          w_serve_cpu;
    logic          w_grant;

    // DMA is only forced in once it has lost STARVE_MAX cycles in a row
    assign w_starved = dma_req && (r_starve_cnt == STARVE_LIM);
    assign cpu_rdata = mem_rdata;
    assign dma_ack   = r_dma_ack;
    assign dma_rdata = r_dma_rdata;

    // State register and ack pulse (ack is high exactly while in DMA_RESP)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_dma_ack <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dma_ack <= (r_state == ST_DMA_ISSUE);
        end
    end

    // Next-state, grant decision and memory port mux
    always_comb begin
        w_state_nxt = r_state;
        w_serve_cpu = 1'b0;
        w_grant     = 1'b0;
        cpu_stall   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_nbytes  = r_req_nbytes;
        mem_addr    = r_req_addr;
        mem_wdata   = r_req_wdata;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req && !w_starved) begin
                    w_serve_cpu = 1'b1;
                end else if (dma_req) begin
                    w_grant     = 1'b1;
                    cpu_stall   = cpu_req;
                    w_state_nxt = ST_DMA_ISSUE;
                end
            end
            ST_DMA_ISSUE: begin
                mem_rd_en   = !r_req_wr;
                mem_wr_en   = r_req_wr;
                cpu_stall   = cpu_req;
                w_state_nxt = ST_DMA_RESP;
            end
            ST_DMA_RESP: begin
                // port is free for the CPU only; no back-to-back DMA grant
                w_serve_cpu = cpu_req;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_serve_cpu) begin
            mem_rd_en  = cpu_rd;
            mem_wr_en  = cpu_wr;
            mem_nbytes = cpu_nbytes;
            mem_addr   = cpu_addr;
            mem_wdata  = cpu_wdata;
        end
    end

    // Capture DMA request fields at grant so the issue cycle is self-contained
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_wr     <= 1'b0;
            r_req_nbytes <= '0;
            r_req_addr   <= '0;
            r_req_wdata  <= '0;
        end else if (w_grant) begin
            r_req_wr     <= dma_wr;
            r_req_nbytes <= dma_nbytes;
            r_req_addr   <= dma_addr;
            r_req_wdata  <= dma_wdata;
        end
    end

    // Count IDLE cycles the DMA loses to the CPU; cleared on grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_grant) begin
            r_starve_cnt <= '0;
        end else if (r_state == ST_IDLE && w_serve_cpu && dma_req &&
                     r_starve_cnt != STARVE_LIM) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // DMA read data is sampled at the end of the issue cycle, held otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dma_rdata <= '0;
        end else if (r_state == ST_DMA_ISSUE && !r_req_wr) begin
            r_dma_rdata <= mem_rdata;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_stat_stall;
    logic [15:0] r_stat_grants;

    assign stat_stall_cycles = r_stat_stall;
    assign stat_dma_grants   = r_stat_grants;

    // Saturating counters of stalled cycles and DMA grants
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_stall  <= '0;
            r_stat_grants <= '0;
        end else begin
            if (cpu_stall && r_stat_stall != 16'hFFFF)
                r_stat_stall <= r_stat_stall + 16'd1;
            if (w_grant && r_stat_grants != 16'hFFFF)
                r_stat_grants <= r_stat_grants + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small behavioural DataMemory.
module tb_dmem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_rd, cpu_wr;
    logic [1:0]    cpu_nbytes;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dma_req, dma_wr;
    logic [1:0]    dma_nbytes;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] dma_rdata;
    logic          dma_ack;
    logic          mem_rd_en, mem_wr_en;
    logic [1:0]    mem_nbytes;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   stat_stall_cycles;
    logic [15:0]   stat_dma_grants;
`endif

    logic [DW-1:0] mem [0:255];
    int            wr_cnt = 0;
    int            n_cmp  = 0;
    int            n_err  = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_nbytes(cpu_nbytes), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_nbytes(dma_nbytes),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_nbytes(mem_nbytes),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .stat_stall_cycles(stat_stall_cycles), .stat_dma_grants(stat_dma_grants)
`endif
    );

    // DataMemory: combinational read, write at posedge
    assign mem_rdata = mem_rd_en ? mem[mem_addr[7:0]] : '0;

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after posedge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // outputs are observed mid-cycle (negedge)
    task automatic settle();
        #4;
    endtask

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] st0, gr0;
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 16'hBEEF;
        rst_n = 1'b0;
        cpu_req = 0; cpu_rd = 0; cpu_wr = 0; cpu_nbytes = 2'd0;
        cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_wr = 0; dma_nbytes = 2'd0; dma_addr = '0; dma_wdata = '0;

        // reset state
        tick(); tick();
        settle();
        chk("rst_ack",   32'(dma_ack),   32'h0);
        chk("rst_rdata", 32'(dma_rdata), 32'h0);
        chk("rst_stall", 32'(cpu_stall), 32'h0);
        chk("rst_rden",  32'(mem_rd_en), 32'h0);
        chk("rst_wren",  32'(mem_wr_en), 32'h0);
        tick();
        rst_n = 1'b1;

        // CPU read, no DMA: served same cycle, never stalled
        cpu_req = 1; cpu_rd = 1; cpu_addr = 16'h0010; cpu_nbytes = 2'd1;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("cpu_rdata", 32'(cpu_rdata),  32'hBEEF);
            chk("cpu_stall", 32'(cpu_stall),  32'h0);
            chk("cpu_rden",  32'(mem_rd_en),  32'h1);
            chk("cpu_nbyte", 32'(mem_nbytes), 32'h1);
            tick();
        end
        cpu_req = 0; cpu_rd = 0;
        settle();
        chk("idle_rden", 32'(mem_rd_en), 32'h0);
        chk("idle_wren", 32'(mem_wr_en), 32'h0);
        tick();

        // DMA write 0x20 <- 0x1234: grant, issue (write), resp (ack)
        dma_req = 1; dma_wr = 1; dma_addr = 16'h0020; dma_wdata = 16'h1234; dma_nbytes = 2'd3;
        settle();
        chk("dw_g_wren", 32'(mem_wr_en), 32'h0);
        chk("dw_g_ack",  32'(dma_ack),   32'h0);
        tick();
        settle();
        chk("dw_i_wren",  32'(mem_wr_en),  32'h1);
        chk("dw_i_addr",  32'(mem_addr),   32'h0020);
        chk("dw_i_wdata", 32'(mem_wdata),  32'h1234);
        chk("dw_i_nbyte", 32'(mem_nbytes), 32'h3);
        chk("dw_i_ack",   32'(dma_ack),    32'h0);
        tick();
        settle();
        chk("dw_r_ack",   32'(dma_ack),   32'h1);
        chk("dw_r_wren",  32'(mem_wr_en), 32'h0);
        chk("dw_r_rdata", 32'(dma_rdata), 32'h0);
        dma_req = 0;
        tick();
        settle();
        chk("dw_ack_off", 32'(dma_ack), 32'h0);
        chk("dw_mem",     32'(mem[8'h20]), 32'h1234);
        tick();

        // DMA read back 0x20
        dma_req = 1; dma_wr = 0; dma_nbytes = 2'd1;
        tick();
        settle();
        chk("dr_i_rden", 32'(mem_rd_en), 32'h1);
        chk("dr_i_addr", 32'(mem_addr),  32'h0020);
        tick();
        settle();
        chk("dr_r_ack",   32'(dma_ack),   32'h1);
        chk("dr_r_rdata", 32'(dma_rdata), 32'h1234);
        dma_req = 0;
        tick();
        settle();
        chk("dr_ack_off",  32'(dma_ack),   32'h0);
        chk("dr_hold_rd",  32'(dma_rdata), 32'h1234);

        // Both requests held high from starve_cnt=0: 4 CPU, grant, issue, resp(CPU)
`ifdef DMEM_ARB_STATS_EN
        st0 = stat_stall_cycles;
        gr0 = stat_dma_grants;
`endif
        tick();
        cpu_req = 1; cpu_rd = 1; cpu_addr = 16'h0010;
        dma_req = 1; dma_wr = 0; dma_addr = 16'h0020;
        for (int k = 0; k < 4 * (STARVE_MAX + 3); k++) begin
            int ph;
            ph = k % (STARVE_MAX + 3);
            settle();
            chk($sformatf("ct_stall%0d", k), 32'(cpu_stall), 32'((ph == STARVE_MAX) || (ph == STARVE_MAX + 1)));
            chk($sformatf("ct_ack%0d", k),   32'(dma_ack),   32'(ph == STARVE_MAX + 2));
            chk($sformatf("ct_rden%0d", k),  32'(mem_rd_en), 32'(ph != STARVE_MAX));
            if (ph == STARVE_MAX + 1)
                chk($sformatf("ct_daddr%0d", k), 32'(mem_addr), 32'h0020);
            else if (ph != STARVE_MAX)
                chk($sformatf("ct_crd%0d", k), 32'(cpu_rdata), 32'hBEEF);
            if (ph == STARVE_MAX + 2)
                chk($sformatf("ct_drd%0d", k), 32'(dma_rdata), 32'h1234);
            tick();
        end
`ifdef DMEM_ARB_STATS_EN
        settle();
        chk("stat_grants", 32'(stat_dma_grants - gr0),   32'd4);
        chk("stat_stalls", 32'(stat_stall_cycles - st0), 32'd8);
        tick();
`endif

        // Reset during DMA_ISSUE: request dropped, no ack
        cpu_req = 0; cpu_rd = 0;
        dma_req = 1; dma_wr = 0; dma_addr = 16'h0010;
        tick();
        settle();
        chk("rst_i_rden", 32'(mem_rd_en), 32'h1);
        rst_n = 0; dma_req = 0;
        tick();
        settle();
        chk("rst2_ack",   32'(dma_ack),   32'h0);
        chk("rst2_rdata", 32'(dma_rdata), 32'h0);
        chk("rst2_rden",  32'(mem_rd_en), 32'h0);
`ifdef DMEM_ARB_STATS_EN
        chk("rst2_stst",  32'(stat_stall_cycles), 32'h0);
        chk("rst2_stgr",  32'(stat_dma_grants),   32'h0);
`endif
        tick();
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("rst_noack%0d", k), 32'(dma_ack), 32'h0);
            tick();
        end

        // the single DMA write happened exactly once
        chk("wr_once", 32'(wr_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
